// File: rtl/remote_rx_arbiter.sv
// remote_rx_arbiter
// Shares one RemoteController serial decoder between two IR receivers.
// The first channel to pull its line low owns the decoder for exactly one
// frame (forwarded with one cycle of latency). After the frame the decoder
// line is held idle-high for a guard period. Decoded keys are captured
// together with the channel that produced them.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate the winner of
// simultaneous frame starts. Without it channel 0 always wins a tie.

module remote_rx_arbiter #(
  parameter int FRAME_BITS = 33,
  parameter int GUARD      = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Serial0,
  input  logic       Serial1,
  output logic       DecSerial,
  input  logic [7:0] DecTecla,
  input  logic       DecReady,
  output logic [7:0] Tecla,
  output logic       Source,
  output logic       Valid,
  output logic       Busy,
  output logic       Dropped
);

  localparam int CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int GRD_W = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [GRD_W-1:0] LAST_GRD = GRD_W'(GUARD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK  = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_bitCnt;
  logic [CNT_W-1:0] w_bitCntNext;
  logic [GRD_W-1:0] r_guardCnt;
  logic [GRD_W-1:0] w_guardCntNext;
  logic             r_grant;
  logic             w_grantNext;
  logic             r_last;
  logic             r_prev0;
  logic             r_prev1;
  logic             r_decSerial;
  logic             w_decSerialNext;
  logic             r_dropped;
  logic             w_droppedNext;
  logic [7:0]       r_tecla;
  logic             r_source;
  logic             r_valid;
  logic             w_tieWinner;
  logic             w_capture;

  // Winner of a simultaneous start: the channel that did not produce the last key,
  // or always channel 0 in the fixed-priority build (r_last is folded out there)
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    w_tieWinner = ~r_last;
`else
    w_tieWinner = 1'b0 & r_last;
`endif
  end

  // Next-state logic: arbitration in IDLE, bit forwarding in LOCK, idle-high in GUARD
  always_comb begin
    w_stateNext     = r_state;
    w_bitCntNext    = r_bitCnt;
    w_guardCntNext  = r_guardCnt;
    w_grantNext     = r_grant;
    w_decSerialNext = 1'b1;
    w_droppedNext   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!Serial0 || !Serial1) begin
          if (!Serial0 && !Serial1) begin
            w_grantNext   = w_tieWinner;
            w_droppedNext = 1'b1;
          end else begin
            w_grantNext = ~Serial1;
          end
          w_decSerialNext = 1'b0;
          w_bitCntNext    = '0;
          w_stateNext     = ST_LOCK;
        end
      end
      ST_LOCK: begin
        w_decSerialNext = r_grant ? Serial1 : Serial0;
        w_droppedNext   = r_grant ? (r_prev0 & ~Serial0) : (r_prev1 & ~Serial1);
        if (r_bitCnt == LAST_BIT) begin
          w_decSerialNext = 1'b1;
          w_guardCntNext  = '0;
          w_stateNext     = ST_GUARD;
        end else begin
          w_bitCntNext = r_bitCnt + 1'b1;
        end
      end
      ST_GUARD: begin
        if (r_guardCnt == LAST_GRD) begin
          w_stateNext = ST_IDLE;
        end else begin
          w_guardCntNext = r_guardCnt + 1'b1;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // State register plus the registered decoder line and refusal pulse
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_bitCnt    <= '0;
      r_guardCnt  <= '0;
      r_grant     <= 1'b0;
      r_decSerial <= 1'b1;
      r_dropped   <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_bitCnt    <= w_bitCntNext;
      r_guardCnt  <= w_guardCntNext;
      r_grant     <= w_grantNext;
      r_decSerial <= w_decSerialNext;
      r_dropped   <= w_droppedNext;
    end
  end

  // Previous line levels, used to spot a competing frame start while locked
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_prev0 <= 1'b1;
      r_prev1 <= 1'b1;
    end else begin
      r_prev0 <= Serial0;
      r_prev1 <= Serial1;
    end
  end

  assign w_capture = DecReady && (r_state != ST_IDLE);

  // Key capture: decoder results only count while a frame owns the decoder
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_tecla  <= 8'h00;
      r_source <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b1;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_tecla  <= DecTecla;
        r_source <= r_grant;
        r_last   <= r_grant;
      end
    end
  end

  assign DecSerial = r_decSerial;
  assign Tecla     = r_tecla;
  assign Source    = r_source;
  assign Valid     = r_valid;
  assign Busy      = (r_state != ST_IDLE);
  assign Dropped   = r_dropped;

endmodule

// File: tb/tb_remote_rx_arbiter.sv
// tb_remote_rx_arbiter
// Directed bench for remote_rx_arbiter. A table of whole-frame scenarios is
// applied in a loop; reset mid-frame and simultaneous starts are hand-written
// sequences. The bench plays the decoder: it rebuilds the frame from
// DecSerial and answers with DecReady/DecTecla when key and inverse agree.
`timescale 1ns/1ps

module tb_remote_rx_arbiter;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Serial0;
  logic       Serial1;
  logic       DecSerial;
  logic [7:0] DecTecla;
  logic       DecReady;
  logic [7:0] Tecla;
  logic       Source;
  logic       Valid;
  logic       Busy;
  logic       Dropped;

  int checks = 0;
  int passes = 0;

  // One scenario: two channel frames with start cycles (-1 = silent) and expectations
  typedef struct {
    logic [32:0] f0;
    logic [32:0] f1;
    int          s0;
    int          s1;
    logic        expGrant;
    int          expValid;
    logic [7:0]  expTecla;
    logic        expSource;
    logic        expDrop0;
    int          expDrops;
  } vec_t;

  vec_t vecs[4];

  always #5 Clock = ~Clock;

  remote_rx_arbiter dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Serial0   (Serial0),
    .Serial1   (Serial1),
    .DecSerial (DecSerial),
    .DecTecla  (DecTecla),
    .DecReady  (DecReady),
    .Tecla     (Tecla),
    .Source    (Source),
    .Valid     (Valid),
    .Busy      (Busy),
    .Dropped   (Dropped)
  );

  // Frame layout: bit 0 lead (low), then custom, key, inverted key
  function automatic logic [32:0] mkFrame(input logic [15:0] cust, input logic [7:0] key,
                                          input logic [7:0] inv);
    return {inv, key, cust, 1'b0};
  endfunction

  function automatic vec_t mkVec(input logic [32:0] f0, input logic [32:0] f1, input int s0,
                                 input int s1, input logic g, input int v, input logic [7:0] t,
                                 input logic src, input logic d0, input int dn);
    vec_t r;
    r.f0 = f0; r.f1 = f1; r.s0 = s0; r.s1 = s1;
    r.expGrant = g; r.expValid = v; r.expTecla = t; r.expSource = src;
    r.expDrop0 = d0; r.expDrops = dn;
    return r;
  endfunction

  // Line level of a channel at cycle c; channels only drive during the frame window
  function automatic logic lvl(input logic [32:0] f, input int s, input int c);
    if (s < 0 || c < s || c > 32) return 1'b1;
    return f[c - s];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyReset(input string tag);
    Reset = 1'b0; Serial0 = 1'b1; Serial1 = 1'b1; DecReady = 1'b0; DecTecla = 8'h00;
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b1;
    #1;
    checkOutput({tag, "_decserial"}, DecSerial, 1);
    checkOutput({tag, "_tecla"}, Tecla, 0);
    checkOutput({tag, "_source"}, Source, 0);
    checkOutput({tag, "_valid"}, Valid, 0);
    checkOutput({tag, "_busy"}, Busy, 0);
    checkOutput({tag, "_dropped"}, Dropped, 0);
    @(posedge Clock);
    #1;
  endtask

  // Drives 40 cycles of both lines, decodes DecSerial, and tallies the outputs
  task automatic applyStimulus(input vec_t v, output logic [32:0] rx, output int busyN,
                               output int busyLast, output int validN, output int validAt,
                               output int dropN, output logic drop0, output int guardErrs);
    logic       decOk;
    logic [7:0] decKey;
    rx = '1; busyN = 0; busyLast = -1; validN = 0; validAt = -1;
    dropN = 0; drop0 = 1'b0; guardErrs = 0; decOk = 1'b0; decKey = 8'h00;
    for (int c = 0; c < 40; c++) begin
      Serial0  = lvl(v.f0, v.s0, c);
      Serial1  = lvl(v.f1, v.s1, c);
      DecReady = (c == 33) && decOk;
      DecTecla = decKey;
      @(posedge Clock);
      #1;
      if (c <= 32) rx[c] = DecSerial;
      else if (DecSerial !== 1'b1) guardErrs++;
      if (c == 32) begin
        decKey = rx[24:17];
        decOk  = (rx[0] == 1'b0) && (rx[32:25] == ~rx[24:17]);
      end
      if (Busy) begin busyN++; busyLast = c; end
      if (Valid) begin validN++; if (validAt < 0) validAt = c; end
      if (Dropped) begin dropN++; if (c == 0) drop0 = 1'b1; end
    end
    Serial0 = 1'b1; Serial1 = 1'b1; DecReady = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input vec_t v);
    logic [32:0] rx;
    int busyN, busyLast, validN, validAt, dropN, guardErrs;
    logic drop0;
    applyStimulus(v, rx, busyN, busyLast, validN, validAt, dropN, drop0, guardErrs);
    checkOutput({tag, "_rx"}, rx, v.expGrant ? v.f1 : v.f0);
    checkOutput({tag, "_guard_idle"}, guardErrs, 0);
    checkOutput({tag, "_busy_cycles"}, busyN, 35);
    checkOutput({tag, "_busy_last"}, busyLast, 34);
    checkOutput({tag, "_valid_count"}, validN, v.expValid);
    if (v.expValid > 0) checkOutput({tag, "_valid_at"}, validAt, 33);
    checkOutput({tag, "_tecla"}, Tecla, v.expTecla);
    checkOutput({tag, "_source"}, Source, v.expSource);
    checkOutput({tag, "_drop_first"}, drop0, v.expDrop0);
    if (v.expDrops >= 0) checkOutput({tag, "_drops"}, dropN, v.expDrops);
  endtask

  initial begin
    logic [32:0] f;
    int          validN;
    vec_t        fresh;
    vec_t        sim1;
    vec_t        sim2;

    vecs[0] = mkVec(mkFrame(16'hAAAA, 8'h0F, 8'hF0), 33'h1FFFFFFFF, 0, -1, 1'b0, 1, 8'h0F, 1'b0, 1'b0, 0);
    vecs[1] = mkVec(33'h1FFFFFFFF, mkFrame(16'hAAAA, 8'h0F, 8'h00), -1, 0, 1'b1, 0, 8'h0F, 1'b0, 1'b0, 0);
    vecs[2] = mkVec(33'h1FFFFFFFF, mkFrame(16'h1234, 8'h3C, 8'hC3), -1, 0, 1'b1, 1, 8'h3C, 1'b1, 1'b0, 0);
    vecs[3] = mkVec(mkFrame(16'hAAAA, 8'h5A, 8'hA5), 33'h000000000, 0, 10, 1'b0, 1, 8'h5A, 1'b0, 1'b0, 1);

    applyReset("reset");
    for (int i = 0; i < 4; i++) runAndCheck($sformatf("row%0d", i), vecs[i]);

    // Reset in the middle of a frame: outputs must clear without a clock edge
    f = mkFrame(16'h5555, 8'h0F, 8'hF0);
    for (int c = 0; c <= 10; c++) begin
      Serial0 = f[c]; Serial1 = 1'b1;
      @(posedge Clock);
      #1;
    end
    checkOutput("rstmid_busy_before", Busy, 1);
    checkOutput("rstmid_serial_before", DecSerial, 0);
    Reset = 1'b0;
    #1;
    checkOutput("rstmid_decserial", DecSerial, 1);
    checkOutput("rstmid_busy", Busy, 0);
    checkOutput("rstmid_valid", Valid, 0);
    checkOutput("rstmid_tecla", Tecla, 0);
    checkOutput("rstmid_dropped", Dropped, 0);
    Serial0 = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
    validN = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge Clock);
      #1;
      if (Valid || Busy) validN++;
    end
    checkOutput("rstmid_quiet_after", validN, 0);
    fresh = mkVec(33'h1FFFFFFFF, mkFrame(16'hC0DE, 8'h77, 8'h88), -1, 0, 1'b1, 1, 8'h77, 1'b1, 1'b0, 0);
    runAndCheck("fresh", fresh);

    // Simultaneous starts twice from reset
    applyReset("reset2");
`ifdef ARB_ROUND_ROBIN_EN
    sim1 = mkVec(mkFrame(16'h5555, 8'h11, 8'hEE), mkFrame(16'h5555, 8'h22, 8'hDD), 0, 0, 1'b0, 1, 8'h11, 1'b0, 1'b1, -1);
    sim2 = mkVec(mkFrame(16'h5555, 8'h11, 8'hEE), mkFrame(16'h5555, 8'h22, 8'hDD), 0, 0, 1'b1, 1, 8'h22, 1'b1, 1'b1, -1);
`else
    sim1 = mkVec(mkFrame(16'h5555, 8'h11, 8'hEE), mkFrame(16'h5555, 8'h22, 8'hDD), 0, 0, 1'b0, 1, 8'h11, 1'b0, 1'b1, -1);
    sim2 = mkVec(mkFrame(16'h5555, 8'h11, 8'hEE), mkFrame(16'h5555, 8'h22, 8'hDD), 0, 0, 1'b0, 1, 8'h11, 1'b0, 1'b1, -1);
`endif
    runAndCheck("sim1", sim1);
    runAndCheck("sim2", sim2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
